// File: rtl/bcd_display_scanner.sv
// ---------------------------------------------------------------------------
// bcd_display_scanner
// Drives a 3-digit multiplexed 7-segment display from BCD digits.
// - The load strobe captures the digits into a pending register.
// - The pending value moves to the displayed register only at a frame boundary,
//   so a frame never shows a mix of old and new digits.
// - Each digit slot starts with an anti-ghost blanking window.
// - Leading zeros can be suppressed.
//
// Ports
//   clk, rst_n    : clock (rising edge) and asynchronous active-low reset
//   load          : one-cycle strobe that captures ones/tens/hundreds
//   ones, tens    : BCD digits (4 bits each)
//   hundreds      : BCD hundreds digit (2 bits), zero-extended internally
//   blank_lz      : live leading-zero suppression enable
//   seg           : segments {g,f,e,d,c,b,a}; registered; polarity set by ACTIVE_LOW
//   an            : digit enables {hundreds,tens,ones}; registered; polarity set by ACTIVE_LOW
//   frame_tick    : one-cycle pulse in the cycle after the frame boundary
//   upd_pending   : a captured value is waiting for the next frame boundary
// ---------------------------------------------------------------------------
module bcd_display_scanner #(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned BLANK_CYC  = 16,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [1:0] hundreds,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       frame_tick,
  output logic       upd_pending
);

  localparam int unsigned       PRE_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(SCAN_DIV - 1);
  // Inactive (all-off) pin levels; XOR with these applies the output polarity.
  localparam logic [6:0]        SEG_OFF  = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [2:0]        AN_OFF   = ACTIVE_LOW ? 3'b111 : 3'b000;

  typedef enum logic [1:0] {
    SLOT0 = 2'd0,
    SLOT1 = 2'd1,
    SLOT2 = 2'd2
  } slot_e;

  typedef struct packed {
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
  } digits_t;

  // State
  logic [PRE_W-1:0] prescaler_q, prescaler_d;
  slot_e            slot_q, slot_d;
  digits_t          pend_q, pend_d;
  digits_t          disp_q, disp_d;
  logic             pend_valid_q, pend_valid_d;
  logic [6:0]       seg_q, seg_d;
  logic [2:0]       an_q, an_d;
  logic             frame_tick_q, frame_tick_d;

  // Combinational helpers
  logic             last_cyc_c;
  logic             boundary_c;
  logic             blank_phase_c;
  logic [3:0]       cur_digit_c;
  logic             suppress_c;
  logic [2:0]       an_onehot_c;
  logic [6:0]       seg_raw_c;
  logic [2:0]       an_raw_c;

  // Active-high 7-segment decode; anything outside 0..9 shows a dash.
  function automatic logic [6:0] decode_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  assign last_cyc_c    = (prescaler_q == PRE_LAST);
  assign boundary_c    = last_cyc_c && (slot_q == SLOT2);
  assign blank_phase_c = (32'(prescaler_q) < BLANK_CYC);

  // Prescaler and slot sequencing (SLOT0 -> SLOT1 -> SLOT2 -> SLOT0).
  always_comb begin : counter_next
    prescaler_d = prescaler_q + PRE_W'(1);
    slot_d      = slot_q;
    if (last_cyc_c) begin
      prescaler_d = '0;
      case (slot_q)
        SLOT0:   slot_d = SLOT1;
        SLOT1:   slot_d = SLOT2;
        default: slot_d = SLOT0;
      endcase
    end
  end

  // Pending capture and commit; the commit uses the old pending value, so a
  // load on the boundary cycle becomes the next pending value.
  always_comb begin : pending_next
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    disp_d       = disp_q;
    if (boundary_c && pend_valid_q) begin
      disp_d       = pend_q;
      pend_valid_d = 1'b0;
    end
    if (load) begin
      pend_d.ones     = ones;
      pend_d.tens     = tens;
      pend_d.hundreds = {2'b00, hundreds};
      pend_valid_d    = 1'b1;
    end
  end

  // Digit selection, leading-zero suppression, blanking and polarity.
  always_comb begin : output_next
    cur_digit_c = disp_q.ones;
    an_onehot_c = 3'b001;
    suppress_c  = 1'b0;
    case (slot_q)
      SLOT1: begin
        cur_digit_c = disp_q.tens;
        an_onehot_c = 3'b010;
        suppress_c  = blank_lz && (disp_q.hundreds == 4'd0) && (disp_q.tens == 4'd0);
      end
      SLOT2: begin
        cur_digit_c = disp_q.hundreds;
        an_onehot_c = 3'b100;
        suppress_c  = blank_lz && (disp_q.hundreds == 4'd0);
      end
      default: begin
        cur_digit_c = disp_q.ones;
        an_onehot_c = 3'b001;
        suppress_c  = 1'b0;
      end
    endcase

    if (blank_phase_c) begin
      seg_raw_c = 7'h00;
      an_raw_c  = 3'b000;
    end else begin
      // Suppressed digits keep their anode driven, only the segments go dark.
      seg_raw_c = suppress_c ? 7'h00 : decode_seg(cur_digit_c);
      an_raw_c  = an_onehot_c;
    end

    seg_d        = seg_raw_c ^ SEG_OFF;
    an_d         = an_raw_c ^ AN_OFF;
    frame_tick_d = boundary_c;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_q  <= '0;
      slot_q       <= SLOT0;
      pend_q       <= '0;
      disp_q       <= '0;
      pend_valid_q <= 1'b0;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      prescaler_q  <= prescaler_d;
      slot_q       <= slot_d;
      pend_q       <= pend_d;
      disp_q       <= disp_d;
      pend_valid_q <= pend_valid_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign frame_tick  = frame_tick_q;
  assign upd_pending = pend_valid_q;

endmodule
